mips_pipe_ctrl: RTL and testbench
=================================

// Module: mips_pipe_ctrl
// PURPOSE
//  Central sequencer for the 5-stage pipe_MIPS32 pipeline (IF/ID/EX/MEM/WB, no forwarding).
//  Detects RAW hazards on the instruction in ID, inserts bubbles, flushes wrong-path
//  instructions on a taken branch, and drains/stops the pipe on HLT. Keeps cycle, stall
//  and flush performance counters. Sits beside the datapath; drives only enables and flushes.
// PARAMETERS
//  CNT_W       32  width of performance counters (wrap modulo 2**CNT_W)
//  DRAIN_CYC    3  cycles from HLT leaving ID until halted (EX, MEM, WB retire)
// PORTS
//  clk            in   1      pipeline clock
//  reset          in   1      asynchronous, active-high reset
//  if_id_ir       in   32     instruction in ID (IF/ID register)
//  id_ex_ir       in   32     instruction in EX (ID/EX register)
//  ex_mem_ir      in   32     instruction in MEM (EX/MEM register)
//  branch_taken   in   1      EX/MEM holds BEQZ/BNEQZ whose condition is met
//  pc_we          out  1      PC/IF-IF/ID advance enable
//  if_id_flush    out  1      load NOP (32'h0) into IF/ID this edge
//  id_ex_bubble   out  1      load NOP into ID/EX this edge (ID holds)
//  halted         out  1      pipeline fully drained after HLT
//  stall_o        out  1      RAW stall active this cycle
//  cycle_cnt      out  CNT_W  cycles since reset while not halted
//  stall_cnt      out  CNT_W  cycles with stall_o=1
//  flush_cnt      out  CNT_W  taken-branch flush events
// BEHAVIOUR
//  Opcode = ir[31:26]: RR 0-5 (ADD,SUB,AND,OR,SLT,MUL), LW 8, SW 9, ADDI 10, SUBI 11,
//   SLTI 12, BNEQZ 13, BEQZ 14, HLT 63. rs=ir[25:21], rt=ir[20:16], rd=ir[15:11].
//  Dest: RR->rd; LW/ADDI/SUBI/SLTI->rt; SW/branch/HLT/unknown->none. Dest R0 = none.
//  Srcs of ID: RR rs,rt; LW/ALU-imm/branch rs; SW rs,rt; HLT none. R0 never matches.
//  Register file is write-first in WB, so only EX and MEM destinations are checked.
//  RAW: stall_o=1 when any ID src equals dest of id_ex_ir or ex_mem_ir (state RUN).
//   Stall -> pc_we=0, id_ex_bubble=1, IF/ID holds. Max stall 2 cycles per dependence.
//  Branch: branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, pc_we=1 (PC loads target),
//   stall_o=0 that cycle (flush overrides stall); flush_cnt += 1.
//  FSM (registered state, async reset to RUN):
//   RUN: HLT in ID with no stall and no branch_taken -> DRAIN, drain_cnt=DRAIN_CYC-1;
//        pc_we=1 that cycle so HLT moves into EX.
//   DRAIN: pc_we=0, if_id_flush=1 (no further fetch); counts down each cycle;
//        at 0 -> HALTED. branch_taken during DRAIN (HLT was wrong-path) -> RUN,
//        flush outputs as above.
//   HALTED: pc_we=0, if_id_flush=0, id_ex_bubble=0, halted=1; left only by reset.
//  Counters: cycle_cnt +1 every cycle in RUN/DRAIN; stall_cnt +1 when stall_o; all wrap.
//  Reset (async, any state, mid-stall or mid-drain): state RUN, counters 0, drain_cnt 0.
//   While reset=1 all outputs 0 (pc_we forced 0). First edge after release: normal RUN.
//  Unknown opcodes: treated as no dest, no srcs (never stall).
// STRUCTURE
//  mips_pkg: opcode localparams/enum opcode_t, NOP constant, functions
//   has_dest(ir), dest_reg(ir), uses_rs(ir), uses_rt(ir); ctrl_state_t {RUN,DRAIN,HALTED}.
//  Sub-module mips_hazard_detect: combinational ID-vs-EX/MEM compare -> raw_hit.
//  Top holds FSM, drain counter, perf counters, output muxing.
// TESTING
//  1 ADDI R10,R0,200 in EX; LW R3,0(R10)... ID=ADD R1,R10,R2 -> stall_o=1 2 cycles, stall_cnt=2.
//  2 ID=ADD R1,R0,R0 vs EX dest R0 -> no stall; ID=SW R2,-2(R10), MEM dest R2 -> stall 1 cycle.
//  3 branch_taken=1 while RAW stall active -> if_id_flush=1, id_ex_bubble=1, pc_we=1, flush_cnt=1.
//  4 HLT in ID -> DRAIN, halted=1 exactly 4 edges later; cycle_cnt then frozen.
//  5 branch_taken in DRAIN cycle 1 -> back to RUN, halted never set; reset in DRAIN -> RUN, counters 0.
//  6 Integration: factorial loop N=8 (DataMem[200]=8) -> DataMem[198]=40320, halted=1, flush_cnt=7.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the pipe_MIPS32 pipeline controller: opcodes, controller
// states and the instruction-decode helpers used for RAW hazard detection.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_ADD   = 6'd0,
    OP_SUB   = 6'd1,
    OP_AND   = 6'd2,
    OP_OR    = 6'd3,
    OP_SLT   = 6'd4,
    OP_MUL   = 6'd5,
    OP_LW    = 6'd8,
    OP_SW    = 6'd9,
    OP_ADDI  = 6'd10,
    OP_SUBI  = 6'd11,
    OP_SLTI  = 6'd12,
    OP_BNEQZ = 6'd13,
    OP_BEQZ  = 6'd14,
    OP_HLT   = 6'd63
  } opcode_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  function automatic logic is_rr(input logic [31:0] ir);
    return (ir[31:26] <= 6'd5);
  endfunction

  // Returns the written register, or R0 when the instruction writes nothing.
  function automatic logic [4:0] dest_reg(input logic [31:0] ir);
    logic [4:0] d;
    d = 5'd0;
    if (is_rr(ir)) begin
      d = ir[15:11];
    end else begin
      case (ir[31:26])
        OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: d = ir[20:16];
        default:                          d = 5'd0;
      endcase
    end
    return d;
  endfunction

  function automatic logic has_dest(input logic [31:0] ir);
    return (dest_reg(ir) != 5'd0);
  endfunction

  function automatic logic uses_rs(input logic [31:0] ir);
    logic u;
    u = 1'b0;
    if (is_rr(ir)) begin
      u = 1'b1;
    end else begin
      case (ir[31:26])
        OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_SLTI, OP_BNEQZ, OP_BEQZ: u = 1'b1;
        default:                                                    u = 1'b0;
      endcase
    end
    return u;
  endfunction

  function automatic logic uses_rt(input logic [31:0] ir);
    return is_rr(ir) || (ir[31:26] == OP_SW);
  endfunction

endpackage

// File: rtl/mips_hazard_detect.sv
// Combinational RAW check of the instruction in ID against the destinations of
// the instructions in EX and MEM (WB is covered by the write-first register file).
module mips_hazard_detect
  import mips_pkg::*;
(
  input  logic [31:0] if_id_ir,
  input  logic [31:0] id_ex_ir,
  input  logic [31:0] ex_mem_ir,
  output logic        raw_hit
);

  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] ex_dst;
  logic [4:0] mem_dst;
  logic       ex_wr;
  logic       mem_wr;
  logic       rs_hit;
  logic       rt_hit;

  always_comb begin
    rs      = if_id_ir[25:21];
    rt      = if_id_ir[20:16];
    ex_dst  = dest_reg(id_ex_ir);
    mem_dst = dest_reg(ex_mem_ir);
    ex_wr   = has_dest(id_ex_ir);
    mem_wr  = has_dest(ex_mem_ir);
    // R0 is hard-wired, so a zero source can never be a real dependence.
    rs_hit  = uses_rs(if_id_ir) && (rs != 5'd0) &&
              ((ex_wr && (rs == ex_dst)) || (mem_wr && (rs == mem_dst)));
    rt_hit  = uses_rt(if_id_ir) && (rt != 5'd0) &&
              ((ex_wr && (rt == ex_dst)) || (mem_wr && (rt == mem_dst)));
    raw_hit = rs_hit || rt_hit;
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline sequencer: RAW bubbles, taken-branch flushes, HLT drain/stop and
// performance counters. Drives only enables and flushes of the datapath.
module mips_pipe_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_id_ir,
  input  logic [31:0]      id_ex_ir,
  input  logic [31:0]      ex_mem_ir,
  input  logic             branch_taken,
  output logic             pc_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic             stall_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  localparam int DW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

  ctrl_state_t   state_q;
  ctrl_state_t   state_d;
  logic [DW-1:0] drain_q;
  logic [DW-1:0] drain_d;
  logic          raw_hit;
  logic          cyc_inc;
  logic          flush_inc;

  mips_hazard_detect u_hazard (
    .if_id_ir  (if_id_ir),
    .id_ex_ir  (id_ex_ir),
    .ex_mem_ir (ex_mem_ir),
    .raw_hit   (raw_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      drain_q   <= '0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (cyc_inc)   cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (stall_o)   stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Everything is gated by reset so the datapath sees no enables while reset is held.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_we        = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    stall_o      = 1'b0;
    halted       = 1'b0;
    cyc_inc      = 1'b0;
    flush_inc    = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          cyc_inc = 1'b1;
          if (branch_taken) begin
            // Flush wins over a pending stall: the stalled instruction is wrong-path.
            pc_we        = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
          end else if (raw_hit) begin
            stall_o      = 1'b1;
            id_ex_bubble = 1'b1;
          end else begin
            pc_we = 1'b1;
            if (if_id_ir[31:26] == OP_HLT) begin
              state_d = DRAIN;
              drain_d = DW'(DRAIN_CYC - 1);
            end
          end
        end
        DRAIN: begin
          cyc_inc = 1'b1;
          if (branch_taken) begin
            // HLT was fetched down the wrong path; resume from the branch target.
            pc_we        = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            state_d      = RUN;
            drain_d      = '0;
          end else begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (drain_q == '0) begin
              state_d = HALTED;
            end else begin
              drain_d = drain_q - DW'(1);
            end
          end
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: begin
          state_d = RUN;
          drain_d = '0;
        end
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed bench for mips_pipe_ctrl: a table of single-cycle hazard/flush vectors
// followed by hand-written stall, branch, drain and reset sequences.
module tb_mips_pipe_ctrl;

  localparam int CNT_W = 32;

  localparam logic [5:0] T_ADD = 6'd0, T_MUL = 6'd5, T_LW = 6'd8, T_SW = 6'd9;
  localparam logic [5:0] T_ADDI = 6'd10, T_SLTI = 6'd12, T_BNEQZ = 6'd13;
  localparam logic [5:0] T_BEQZ = 6'd14, T_BAD = 6'd20;
  localparam logic [31:0] T_NOP = 32'h0000_0000;
  localparam logic [31:0] T_HLT = 32'hFC00_0000;
  localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALTED = 2'd2;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      if_id_ir, id_ex_ir, ex_mem_ir;
  logic             branch_taken;
  logic             pc_we, if_id_flush, id_ex_bubble, halted, stall_o;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  int n_edges = 0;
  logic [3:0] exp_q[$];

  mips_pipe_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_id_ir     (if_id_ir),
    .id_ex_ir     (id_ex_ir),
    .ex_mem_ir    (ex_mem_ir),
    .branch_taken (branch_taken),
    .pc_we        (pc_we),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .halted       (halted),
    .stall_o      (stall_o),
    .cycle_cnt    (cycle_cnt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ctl();
    return {pc_we, if_id_flush, id_ex_bubble, stall_o};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] id, input logic [31:0] ex,
                       input logic [31:0] mem, input logic bt);
    if_id_ir     = id;
    id_ex_ir     = ex;
    ex_mem_ir    = mem;
    branch_taken = bt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n_edges++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(T_NOP, T_NOP, T_NOP, 1'b0);
    @(negedge clk);
    reset   = 1'b0;
    n_edges = 0;
    @(posedge clk);
    #1;
    n_edges++;
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    string       name;
    logic [31:0] id;
    logic [31:0] ex;
    logic [31:0] mem;
    logic        bt;
    logic [3:0]  exp;   // {pc_we, if_id_flush, id_ex_bubble, stall_o}
  } vec_t;

  function automatic vec_t mk(input string n, input logic [31:0] id, input logic [31:0] ex,
                              input logic [31:0] mem, input logic bt, input logic [3:0] e);
    vec_t v;
    v.name = n; v.id = id; v.ex = ex; v.mem = mem; v.bt = bt; v.exp = e;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int exp_stalls;
    int exp_flushes;
    logic [3:0] e;
    logic [CNT_W-1:0] frozen;

    tbl.push_back(mk("all_nop",      T_NOP, T_NOP, T_NOP, 1'b0, 4'b1000));
    tbl.push_back(mk("rr_rs_ex",     rr(T_ADD, 2, 3, 1), ri(T_ADDI, 0, 2, 16'd5), T_NOP, 1'b0, 4'b0011));
    tbl.push_back(mk("rr_rt_mem",    rr(T_ADD, 2, 3, 1), T_NOP, rr(T_ADD, 4, 5, 3), 1'b0, 4'b0011));
    tbl.push_back(mk("imm_rs_ex",    ri(T_ADDI, 6, 4, 16'd7), ri(T_ADDI, 1, 6, 16'd1), T_NOP, 1'b0, 4'b0011));
    tbl.push_back(mk("imm_rt_nosrc", ri(T_ADDI, 5, 4, 16'd7), rr(T_ADD, 1, 2, 4), T_NOP, 1'b0, 4'b1000));
    tbl.push_back(mk("lw_rs_mem",    ri(T_LW, 7, 3, 16'd0), T_NOP, ri(T_LW, 1, 7, 16'd4), 1'b0, 4'b0011));
    tbl.push_back(mk("sw_no_dest",   ri(T_SW, 1, 8, 16'd0), ri(T_SW, 8, 8, 16'd0), T_NOP, 1'b0, 4'b1000));
    tbl.push_back(mk("sw_rt_ex",     ri(T_SW, 1, 8, 16'd0), ri(T_SLTI, 2, 8, 16'd3), T_NOP, 1'b0, 4'b0011));
    tbl.push_back(mk("beqz_rs_ex",   ri(T_BEQZ, 9, 0, 16'hFFFD), ri(T_SLTI, 1, 9, 16'd3), T_NOP, 1'b0, 4'b0011));
    tbl.push_back(mk("r0_dest",      ri(T_BNEQZ, 0, 0, 16'd2), rr(T_ADD, 1, 2, 0), T_NOP, 1'b0, 4'b1000));
    tbl.push_back(mk("unknown_op",   rr(T_BAD, 5, 5, 1), rr(T_ADD, 1, 2, 5), T_NOP, 1'b0, 4'b1000));
    tbl.push_back(mk("mul_dest",     rr(T_ADD, 2, 3, 1), rr(T_MUL, 6, 7, 2), T_NOP, 1'b0, 4'b0011));
    tbl.push_back(mk("branch_raw",   rr(T_ADD, 2, 3, 1), ri(T_ADDI, 0, 2, 16'd5), T_NOP, 1'b1, 4'b1110));
    tbl.push_back(mk("branch_clean", T_NOP, T_NOP, T_NOP, 1'b1, 4'b1110));
    tbl.push_back(mk("no_match",     rr(T_ADD, 2, 3, 1), rr(T_ADD, 2, 3, 9), ri(T_SW, 1, 3, 16'd0), 1'b0, 4'b1000));

    reset = 1'b1;
    drive(T_NOP, T_NOP, T_NOP, 1'b0);
    #12;
    chk("reset_outputs", {pc_we, if_id_flush, id_ex_bubble, halted, stall_o, dbg_state}, 7'd0);
    chk("reset_counters", {cycle_cnt, stall_cnt}, 64'd0);
    chk("reset_flush_cnt", flush_cnt, 0);
    @(negedge clk);
    reset   = 1'b0;
    n_edges = 0;
    drive(T_NOP, T_NOP, T_NOP, 1'b0);
    chk("release_pc_we", pc_we, 1'b1);

    // ---------------- table-driven single cycles ----------------
    exp_stalls  = 0;
    exp_flushes = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      n_edges++;
      drive(tbl[i].id, tbl[i].ex, tbl[i].mem, tbl[i].bt);
      exp_q.push_back(tbl[i].exp);
      if (tbl[i].exp[0]) exp_stalls++;
      if (tbl[i].bt) exp_flushes++;
      e = exp_q.pop_front();
      chk(tbl[i].name, ctl(), e);
    end
    tick();
    chk("tbl_stall_cnt", stall_cnt, exp_stalls);
    chk("tbl_flush_cnt", flush_cnt, exp_flushes);
    chk("tbl_cycle_cnt", cycle_cnt, n_edges);

    // ---------------- ADDI R10 then ADD R1,R10,R2: two stall cycles ----------------
    do_reset();
    drive(rr(T_ADD, 10, 2, 1), ri(T_ADDI, 0, 10, 16'd200), T_NOP, 1'b0);
    chk("s1_stall_c1", ctl(), 4'b0011);
    tick();
    drive(rr(T_ADD, 10, 2, 1), T_NOP, ri(T_ADDI, 0, 10, 16'd200), 1'b0);
    chk("s1_stall_c2", ctl(), 4'b0011);
    tick();
    drive(rr(T_ADD, 10, 2, 1), T_NOP, T_NOP, 1'b0);
    chk("s1_release", ctl(), 4'b1000);
    chk("s1_stall_cnt", stall_cnt, 2);

    // ---------------- R0 dest no stall; SW vs MEM dest one stall ----------------
    do_reset();
    drive(rr(T_ADD, 0, 0, 1), ri(T_ADDI, 5, 0, 16'd3), T_NOP, 1'b0);
    chk("s2_r0_nostall", stall_o, 1'b0);
    tick();
    drive(ri(T_SW, 10, 2, 16'hFFFE), T_NOP, rr(T_ADD, 3, 4, 2), 1'b0);
    chk("s2_sw_stall", ctl(), 4'b0011);
    tick();
    drive(ri(T_SW, 10, 2, 16'hFFFE), T_NOP, T_NOP, 1'b0);
    chk("s2_sw_release", ctl(), 4'b1000);
    chk("s2_stall_cnt", stall_cnt, 1);

    // ---------------- branch during a RAW stall ----------------
    do_reset();
    drive(rr(T_ADD, 10, 2, 1), ri(T_ADDI, 0, 10, 16'd200), T_NOP, 1'b0);
    chk("s3_pre_stall", stall_o, 1'b1);
    drive(rr(T_ADD, 10, 2, 1), ri(T_ADDI, 0, 10, 16'd200), T_NOP, 1'b1);
    chk("s3_flush_wins", ctl(), 4'b1110);
    tick();
    drive(T_NOP, T_NOP, T_NOP, 1'b0);
    chk("s3_flush_cnt", flush_cnt, 1);
    chk("s3_stall_cnt", stall_cnt, 0);

    // ---------------- HLT drain: halted exactly 4 edges later ----------------
    do_reset();
    tick();
    drive(T_HLT, T_NOP, T_NOP, 1'b0);
    chk("s4_hlt_advance", {ctl(), dbg_state}, {4'b1000, S_RUN});
    tick();
    drive(rr(T_ADD, 1, 1, 1), T_HLT, T_NOP, 1'b0);
    chk("s4_drain_c1", {ctl(), halted, dbg_state}, {4'b0110, 1'b0, S_DRAIN});
    tick();
    chk("s4_drain_c2", {pc_we, halted}, 2'b00);
    tick();
    chk("s4_drain_c3", {pc_we, if_id_flush, halted}, 3'b010);
    tick();
    chk("s4_halted", {ctl(), halted, dbg_state}, {4'b0000, 1'b1, S_HALTED});
    chk("s4_cycle_cnt", cycle_cnt, n_edges);
    frozen = cycle_cnt;
    drive(rr(T_ADD, 2, 3, 1), ri(T_ADDI, 0, 2, 16'd5), T_NOP, 1'b0);
    tick();
    tick();
    tick();
    chk("s4_halted_quiet", {ctl(), halted}, 5'b00001);
    chk("s4_cycle_frozen", cycle_cnt, frozen);
    chk("s4_stall_cnt", stall_cnt, 0);

    // ---------------- branch in DRAIN cycle 1 cancels the halt ----------------
    do_reset();
    drive(T_HLT, T_NOP, T_NOP, 1'b0);
    tick();
    drive(T_NOP, T_HLT, T_NOP, 1'b1);
    chk("s5_drain_branch", {ctl(), dbg_state}, {4'b1110, S_DRAIN});
    tick();
    drive(T_NOP, T_NOP, T_NOP, 1'b0);
    chk("s5_back_to_run", {ctl(), dbg_state}, {4'b1000, S_RUN});
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("s5_never_halted", {halted, dbg_state}, {1'b0, S_RUN});
    end
    chk("s5_flush_cnt", flush_cnt, 1);

    // ---------------- reset in the middle of DRAIN ----------------
    drive(T_HLT, T_NOP, T_NOP, 1'b0);
    tick();
    drive(T_NOP, T_HLT, T_NOP, 1'b0);
    tick();
    chk("s5_in_drain", dbg_state, S_DRAIN);
    #2;
    reset = 1'b1;
    #1;
    chk("s5_rst_outputs", {pc_we, if_id_flush, id_ex_bubble, halted, stall_o, dbg_state}, 7'd0);
    chk("s5_rst_counters", {cycle_cnt, flush_cnt}, 64'd0);
    @(negedge clk);
    reset   = 1'b0;
    n_edges = 0;
    drive(T_NOP, T_NOP, T_NOP, 1'b0);
    tick();
    chk("s5_post_rst", {ctl(), dbg_state}, {4'b1000, S_RUN});
    chk("s5_post_cycle", cycle_cnt, 1);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
